demux8_deser: RTL and testbench

DEMUX8_DESER -- requirements
Module: demux8_deser

---
 rtl/demux8_deser.sv | 81 ++++++++
 tb/tb_demux8_deser.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/demux8_deser.sv
// Serial-to-parallel deserializer: collects 8 accepted bits LSB-first and presents
// the word on Y with a valid/ready output register that can hold one pending word.
module demux8_deser (
  input  logic       clk,
  input  logic       reset,
  input  logic       D,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] Y,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] sel
);

  // Handshake: a transfer happens on a rising clk edge where valid and ready are
  // both 1; valid never waits on ready, and ready may depend combinationally on valid
  // only on the output side (in_ready looks at out_ready, never at in_valid).

  // Output register state; out_valid is the externally visible encoding of it.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t     state, state_next;
  logic [7:0] assy, assy_next;
  logic [7:0] y_next;
  logic [2:0] sel_next;
  logic       in_xfer;
  logic       out_xfer;
  logic       complete;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign complete = in_xfer & (sel == 3'd7);

  // State register plus datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      sel   <= 3'd0;
      assy  <= 8'h00;
      Y     <= 8'h00;
    end else begin
      state <= state_next;
      sel   <= sel_next;
      assy  <= assy_next;
      Y     <= y_next;
    end
  end

  // Next-state logic for the output register.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (complete) state_next = FULL;
      FULL:  if (out_xfer && !complete) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // Datapath next values: slot write, slot counter, and word load.
  always_comb begin
    assy_next = assy;
    sel_next  = sel;
    y_next    = Y;
    if (in_xfer) begin
      assy_next[sel] = D;
      sel_next       = sel + 3'd1;
    end
    // The last bit bypasses the assembly register so the word is ready one cycle later.
    if (complete) y_next = {D, assy[6:0]};
  end

  // Outputs: only the final slot can stall, and only while the pending word is unconsumed.
  always_comb begin
    out_valid = (state == FULL);
    in_ready  = !((sel == 3'd7) && (state == FULL) && !out_ready);
  end

endmodule

// File: tb/tb_demux8_deser.sv
// Directed bench for demux8_deser: table of per-cycle vectors plus hand-written
// asynchronous-reset sequences.
module tb_demux8_deser;

  logic       clk;
  logic       reset;
  logic       D;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] Y;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] sel;

  int checks;
  int failures;

  typedef struct {
    logic       d;
    logic       v;
    logic       ordy;
    logic       exp_ir;
    logic       exp_ov;
    logic [7:0] exp_y;
    logic [2:0] exp_sel;
  } vec_t;

  vec_t vecs[$];

  demux8_deser dut (
    .clk       (clk),
    .reset     (reset),
    .D         (D),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Y         (Y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel       (sel)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic d, input logic v, input logic ordy,
                              input logic ir, input logic ov, input logic [7:0] y,
                              input logic [2:0] s);
    vec_t t;
    t.d = d; t.v = v; t.ordy = ordy;
    t.exp_ir = ir; t.exp_ov = ov; t.exp_y = y; t.exp_sel = s;
    vecs.push_back(t);
  endfunction

  // Full word at 100% in_valid/out_ready: Y holds the old word until the 8th bit.
  function automatic void add_word(input logic [7:0] w, input logic [7:0] y_before);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) add(w[i], 1'b1, 1'b1, 1'b1, 1'b1, w, 3'd0);
      else        add(w[i], 1'b1, 1'b1, 1'b1, 1'b0, y_before, 3'(i + 1));
    end
  endfunction

  // Called at a negedge: drive, check in_ready, cross one rising edge, check registers.
  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      D         = vecs[i].d;
      in_valid  = vecs[i].v;
      out_ready = vecs[i].ordy;
      #1;
      check($sformatf("%s[%0d].in_ready", tag, i), {7'd0, in_ready}, {7'd0, vecs[i].exp_ir});
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s[%0d].out_valid", tag, i), {7'd0, out_valid}, {7'd0, vecs[i].exp_ov});
      check($sformatf("%s[%0d].Y", tag, i), Y, vecs[i].exp_y);
      check($sformatf("%s[%0d].sel", tag, i), {5'd0, sel}, {5'd0, vecs[i].exp_sel});
    end
    vecs.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".Y"}, Y, 8'h00);
    check({tag, ".out_valid"}, {7'd0, out_valid}, 8'h00);
    check({tag, ".sel"}, {5'd0, sel}, 8'h00);
    check({tag, ".in_ready"}, {7'd0, in_ready}, 8'h01);
  endtask

  logic [7:0] w96;
  logic [7:0] w77;

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    D         = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    w96       = 8'h96;
    w77       = 8'h77;

    // Reset takes effect before any clock edge.
    #2 reset = 1'b1;
    #1 check_reset_state("por");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Basic word, then two back-to-back words with no stall.
    add_word(8'h4D, 8'h00);
    add_word(8'hA5, 8'h4D);
    add_word(8'h3C, 8'hA5);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3C, 3'd0);

    // Gapped in_valid: invalid cycles carry the inverted bit and must be ignored.
    for (int i = 0; i < 8; i++) begin
      add(w96[i], 1'b1, 1'b1, 1'b1, (i == 7), (i == 7) ? 8'h96 : 8'h3C, 3'((i + 1) % 8));
      add(~w96[i], 1'b0, 1'b1, 1'b1, 1'b0, (i == 7) ? 8'h96 : 8'h3C, 3'((i + 1) % 8));
    end

    // 8'hFF completes with the consumer stalled.
    for (int i = 0; i < 8; i++)
      add(1'b1, 1'b1, 1'b0, 1'b1, (i == 7), (i == 7) ? 8'hFF : 8'h96, 3'((i + 1) % 8));
    // Slots 0-6 of 8'h01 are accepted while Y is still full.
    for (int i = 0; i < 7; i++)
      add((i == 0), 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 3'(i + 1));
    // Slot 7 stalls; Y must hold 8'hFF.
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 3'd7);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 3'd7);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 3'd7);
    // Consumer ready: bit accepted the same cycle, Y reloads and stays full.
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 3'd0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 3'd0);

    // Pending 8'h77 plus a partial word at sel=5.
    for (int i = 0; i < 8; i++)
      add(w77[i], 1'b1, 1'b0, 1'b1, (i == 7), (i == 7) ? 8'h77 : 8'h01, 3'((i + 1) % 8));
    for (int i = 0; i < 5; i++)
      add(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h77, 3'(i + 1));
    run_vecs("seq");

    // Asynchronous reset between edges discards both words.
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_state("midreset");
    @(negedge clk);
    reset = 1'b0;

    // No stale out_valid pulse, then a fresh word starting at slot 0.
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0);
    add_word(8'h5A, 8'h00);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, 3'd0);
    run_vecs("post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
